// File: rtl/ibex_obi_sram_bridge.sv
// OBI-style req/gnt/rvalid slave in front of a single-port word SRAM macro without a write mask.
// Partial writes become a one-cycle read-modify-write; accesses outside the address window return a bus error.
module ibex_obi_sram_bridge #(
    parameter int unsigned ADDR_W    = 8,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter bit          RMW_EN    = 1'b1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              req_i,
    output logic              gnt_o,
    input  logic              we_i,
    input  logic [3:0]        be_i,
    input  logic [31:0]       addr_i,
    input  logic [31:0]       wdata_i,
    output logic              rvalid_o,
    output logic [31:0]       rdata_o,
    output logic              err_o,
    output logic              sram_cen_o,
    output logic              sram_wen_o,
    output logic [ADDR_W-1:0] sram_addr_o,
    output logic [31:0]       sram_d_o,
    input  logic [31:0]       sram_q_i
);

    typedef enum logic {IDLE, RMW} state_e;

    state_e            state;
    logic [ADDR_W-1:0] rmw_index;
    logic [31:0]       rmw_wdata;
    logic [3:0]        rmw_be;
    logic              rvalid_q;
    logic              err_q;
    logic              read_q;

    logic [ADDR_W-1:0] index;
    logic              in_window;
    logic              be_full;
    logic              be_none;
    logic              be_partial;
    logic              start_rmw;
    logic              req_err;
    logic              unused_addr_lsb;

    assign index           = addr_i[ADDR_W+1:2];
    assign in_window       = (addr_i[31:ADDR_W+2] == BASE_ADDR[31:ADDR_W+2]);
    assign be_full         = (be_i == 4'hF);
    assign be_none         = (be_i == 4'h0);
    assign be_partial      = !be_full && !be_none;
    assign unused_addr_lsb = ^addr_i[1:0];

    assign gnt_o     = req_i && (state == IDLE);
    assign start_rmw = gnt_o && in_window && we_i && be_partial && RMW_EN;
    assign req_err   = !in_window || (we_i && be_partial && !RMW_EN);

    // Macro port: the RMW write phase has priority, otherwise only granted in-window accesses touch the macro.
    always_comb begin
        sram_cen_o  = 1'b1;
        sram_wen_o  = 1'b1;
        sram_addr_o = '0;
        sram_d_o    = '0;
        if (state == RMW) begin
            sram_cen_o  = 1'b0;
            sram_wen_o  = 1'b0;
            sram_addr_o = rmw_index;
            for (int k = 0; k < 4; k++) begin
                sram_d_o[8*k +: 8] = rmw_be[k] ? rmw_wdata[8*k +: 8] : sram_q_i[8*k +: 8];
            end
        end else if (gnt_o && in_window) begin
            if (!we_i) begin
                sram_cen_o  = 1'b0;
                sram_addr_o = index;
            end else if (be_full) begin
                sram_cen_o  = 1'b0;
                sram_wen_o  = 1'b0;
                sram_addr_o = index;
                sram_d_o    = wdata_i;
            end else if (start_rmw) begin
                sram_cen_o  = 1'b0;
                sram_addr_o = index;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state     <= IDLE;
            rmw_index <= '0;
            rmw_wdata <= '0;
            rmw_be    <= '0;
            rvalid_q  <= 1'b0;
            err_q     <= 1'b0;
            read_q    <= 1'b0;
        end else begin
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
            read_q   <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_rmw) begin
                        state     <= RMW;
                        rmw_index <= index;
                        rmw_wdata <= wdata_i;
                        rmw_be    <= be_i;
                    end else if (gnt_o) begin
                        rvalid_q <= 1'b1;
                        err_q    <= req_err;
                        read_q   <= in_window && !we_i;
                    end
                end
                RMW: begin
                    state    <= IDLE;
                    rvalid_q <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Read data comes straight from the macro in the response cycle; errors and writes return zero.
    assign rvalid_o = rvalid_q;
    assign err_o    = err_q;
    assign rdata_o  = read_q ? sram_q_i : 32'h0;

endmodule

// File: tb/tb_ibex_obi_sram_bridge.sv
// Self-checking bench: two bridge instances (RMW enabled with offset window, RMW disabled at base 0),
// each backed by a behavioural SRAM macro, checked against a word-array reference model.
module tb_ibex_obi_sram_bridge;

    localparam logic [31:0] BASE_A = 32'h0001_0000;
    localparam logic [31:0] BASE_B = 32'h0000_0000;
    localparam int          WORDS  = 256;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic        sel;
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        mem_clear;

    logic        gnt_a, rvalid_a, err_a, cen_a, wen_a;
    logic [31:0] rdata_a, d_a, q_a;
    logic [7:0]  saddr_a;
    logic        gnt_b, rvalid_b, err_b, cen_b, wen_b;
    logic [31:0] rdata_b, d_b, q_b;
    logic [7:0]  saddr_b;

    logic [31:0] mem_a [WORDS];
    logic [31:0] mem_b [WORDS];
    logic [31:0] ref_mem [2][WORDS];

    ibex_obi_sram_bridge #(.ADDR_W(8), .BASE_ADDR(BASE_A), .RMW_EN(1'b1)) dut_a (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req && !sel), .gnt_o(gnt_a), .we_i(we), .be_i(be),
        .addr_i(addr), .wdata_i(wdata), .rvalid_o(rvalid_a), .rdata_o(rdata_a), .err_o(err_a),
        .sram_cen_o(cen_a), .sram_wen_o(wen_a), .sram_addr_o(saddr_a), .sram_d_o(d_a), .sram_q_i(q_a)
    );

    ibex_obi_sram_bridge #(.ADDR_W(8), .BASE_ADDR(BASE_B), .RMW_EN(1'b0)) dut_b (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req && sel), .gnt_o(gnt_b), .we_i(we), .be_i(be),
        .addr_i(addr), .wdata_i(wdata), .rvalid_o(rvalid_b), .rdata_o(rdata_b), .err_o(err_b),
        .sram_cen_o(cen_b), .sram_wen_o(wen_b), .sram_addr_o(saddr_b), .sram_d_o(d_b), .sram_q_i(q_b)
    );

    // Behavioural single-port macros with one-cycle read latency.
    always @(posedge clk) begin
        if (mem_clear) begin
            for (int i = 0; i < WORDS; i++) mem_a[i] <= 32'h0;
        end else if (!cen_a) begin
            if (!wen_a) mem_a[saddr_a] <= d_a;
            else        q_a <= mem_a[saddr_a];
        end
    end

    always @(posedge clk) begin
        if (mem_clear) begin
            for (int i = 0; i < WORDS; i++) mem_b[i] <= 32'h0;
        end else if (!cen_b) begin
            if (!wen_b) mem_b[saddr_b] <= d_b;
            else        q_b <= mem_b[saddr_b];
        end
    end

    logic        gnt, rvalid, err, cen, wen;
    logic [31:0] rdata, d;
    assign gnt    = sel ? gnt_b    : gnt_a;
    assign rvalid = sel ? rvalid_b : rvalid_a;
    assign err    = sel ? err_b    : err_a;
    assign cen    = sel ? cen_b    : cen_a;
    assign wen    = sel ? wen_b    : wen_a;
    assign rdata  = sel ? rdata_b  : rdata_a;
    assign d      = sel ? d_b      : d_a;

    // Reference model: window by byte offset, word array, partial writes merged bytewise.
    task automatic model_txn(input logic t_we, input logic [3:0] t_be, input logic [31:0] t_addr,
                             input logic [31:0] t_wdata, output int e_lat, output logic [31:0] e_rdata,
                             output logic e_err, output logic e_access);
        logic [31:0] base;
        logic [31:0] off;
        int          idx;
        int          s;
        s        = sel ? 1 : 0;
        base     = sel ? BASE_B : BASE_A;
        off      = t_addr - base;
        e_lat    = 1;
        e_rdata  = 32'h0;
        e_err    = 1'b0;
        e_access = 1'b0;
        if (off >= 32'(4 * WORDS)) begin
            e_err = 1'b1;
        end else begin
            idx = int'(off >> 2);
            if (!t_we) begin
                e_rdata  = ref_mem[s][idx];
                e_access = 1'b1;
            end else if (t_be == 4'hF) begin
                ref_mem[s][idx] = t_wdata;
                e_access        = 1'b1;
            end else if (t_be != 4'h0) begin
                if (s == 0) begin
                    for (int k = 0; k < 4; k++)
                        if (t_be[k]) ref_mem[s][idx][8*k +: 8] = t_wdata[8*k +: 8];
                    e_lat    = 2;
                    e_access = 1'b1;
                end else begin
                    e_err = 1'b1;
                end
            end
        end
    endtask

    // Issues one request, returns grant wait, response latency (cycles after grant edge) and response fields.
    task automatic do_txn(input logic t_we, input logic [3:0] t_be, input logic [31:0] t_addr,
                          input logic [31:0] t_wdata, output int lat, output logic [31:0] o_rdata,
                          output logic o_err, output logic o_cen, output int gwait);
        @(negedge clk);
        req = 1'b1; we = t_we; be = t_be; addr = t_addr; wdata = t_wdata;
        #1;
        gwait = 0;
        while (!gnt && gwait < 20) begin
            @(negedge clk);
            #1;
            gwait++;
        end
        o_cen = cen;
        @(posedge clk);
        #1;
        req = 1'b0; we = 1'b0; be = 4'h0; addr = 32'h0; wdata = 32'h0;
        lat     = -1;
        o_rdata = 32'h0;
        o_err   = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (rvalid) begin
                lat     = c;
                o_rdata = rdata;
                o_err   = err;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        mem_clear = 1'b0;
        #1;
        n_checks++;
        if ({rvalid_a, err_a, rdata_a, cen_a, wen_a, saddr_a, d_a, gnt_a} !==
            {1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 8'h0, 32'h0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_a: rv=%0b err=%0b rdata=%h cen=%0b wen=%0b addr=%h d=%h gnt=%0b, expected rv=0 err=0 rdata=0 cen=1 wen=1 addr=0 d=0 gnt=0",
                     rvalid_a, err_a, rdata_a, cen_a, wen_a, saddr_a, d_a, gnt_a);
        end
        n_checks++;
        if ({rvalid_b, err_b, rdata_b, cen_b, wen_b, saddr_b, d_b, gnt_b} !==
            {1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 8'h0, 32'h0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_b: rv=%0b err=%0b rdata=%h cen=%0b gnt=%0b, expected all idle", rvalid_b, err_b, rdata_b, cen_b, gnt_b);
        end
    endtask

    task automatic test_full_write_read();
        int lat, gw, e_lat;
        logic [31:0] r, e_rd;
        logic e, c, e_err, e_acc;
        sel = 1'b0;
        model_txn(1'b1, 4'hF, BASE_A + 32'h10, 32'hDEADBEEF, e_lat, e_rd, e_err, e_acc);
        do_txn(1'b1, 4'hF, BASE_A + 32'h10, 32'hDEADBEEF, lat, r, e, c, gw);
        n_checks++;
        if ({lat, e, c} !== {e_lat, e_err, !e_acc}) begin
            n_fail++;
            $display("FAIL full_write: lat=%0d err=%0b cen=%0b, expected lat=%0d err=%0b cen=%0b", lat, e, c, e_lat, e_err, !e_acc);
        end
        model_txn(1'b0, 4'h0, BASE_A + 32'h10, 32'h0, e_lat, e_rd, e_err, e_acc);
        do_txn(1'b0, 4'h0, BASE_A + 32'h10, 32'h0, lat, r, e, c, gw);
        n_checks++;
        if (lat !== 1 || e !== 1'b0 || r !== 32'hDEADBEEF || r !== e_rd) begin
            n_fail++;
            $display("FAIL full_read: lat=%0d err=%0b rdata=%h, expected lat=1 err=0 rdata=deadbeef", lat, e, r);
        end
    endtask

    task automatic test_partial_write();
        int lat, gw, e_lat;
        logic [31:0] r, e_rd;
        logic e, c, e_err, e_acc;
        sel = 1'b0;
        model_txn(1'b1, 4'hF, BASE_A + 32'h10, 32'h11223344, e_lat, e_rd, e_err, e_acc);
        do_txn(1'b1, 4'hF, BASE_A + 32'h10, 32'h11223344, lat, r, e, c, gw);
        model_txn(1'b1, 4'b0101, BASE_A + 32'h10, 32'hAABBCCDD, e_lat, e_rd, e_err, e_acc);
        @(negedge clk);
        req = 1'b1; we = 1'b1; be = 4'b0101; addr = BASE_A + 32'h10; wdata = 32'hAABBCCDD;
        #1;
        n_checks++;
        if ({gnt, cen, wen} !== 3'b101) begin
            n_fail++;
            $display("FAIL partial_grant: gnt=%0b cen=%0b wen=%0b, expected gnt=1 cen=0 wen=1", gnt, cen, wen);
        end
        @(negedge clk);
        n_checks++;
        if (rvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL partial_early_rvalid: rvalid=%0b, expected 0", rvalid);
        end
        we = 1'b0; be = 4'h0;
        #1;
        n_checks++;
        if ({gnt, cen, wen} !== 3'b000 || d !== 32'h11BB33DD) begin
            n_fail++;
            $display("FAIL partial_rmw_cycle: gnt=%0b cen=%0b wen=%0b d=%h, expected gnt=0 cen=0 wen=0 d=11bb33dd", gnt, cen, wen, d);
        end
        model_txn(1'b0, 4'h0, BASE_A + 32'h10, 32'h0, e_lat, e_rd, e_err, e_acc);
        @(negedge clk);
        n_checks++;
        if (rvalid !== 1'b1 || err !== 1'b0 || rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL partial_response: rvalid=%0b err=%0b rdata=%h, expected rvalid=1 err=0 rdata=0", rvalid, err, rdata);
        end
        #1;
        n_checks++;
        if (gnt !== 1'b1) begin
            n_fail++;
            $display("FAIL partial_regrant: gnt=%0b, expected 1", gnt);
        end
        @(negedge clk);
        n_checks++;
        if (rvalid !== 1'b1 || rdata !== 32'h11BB33DD || rdata !== e_rd) begin
            n_fail++;
            $display("FAIL partial_readback: rvalid=%0b rdata=%h, expected rvalid=1 rdata=11bb33dd", rvalid, rdata);
        end
        req = 1'b0;
    endtask

    task automatic test_window();
        int lat, gw, e_lat;
        logic [31:0] r, e_rd;
        logic e, c, e_err, e_acc;
        sel = 1'b0;
        model_txn(1'b1, 4'hF, 32'h0001_03FC, 32'hC0FFEE01, e_lat, e_rd, e_err, e_acc);
        do_txn(1'b1, 4'hF, 32'h0001_03FC, 32'hC0FFEE01, lat, r, e, c, gw);
        model_txn(1'b0, 4'h0, 32'h0001_0400, 32'h0, e_lat, e_rd, e_err, e_acc);
        do_txn(1'b0, 4'h0, 32'h0001_0400, 32'h0, lat, r, e, c, gw);
        n_checks++;
        if (lat !== 1 || e !== 1'b1 || r !== 32'h0 || c !== 1'b1 || e !== e_err) begin
            n_fail++;
            $display("FAIL window_out: lat=%0d err=%0b rdata=%h cen=%0b, expected lat=1 err=1 rdata=0 cen=1", lat, e, r, c);
        end
        model_txn(1'b0, 4'h0, 32'h0001_03FC, 32'h0, e_lat, e_rd, e_err, e_acc);
        do_txn(1'b0, 4'h0, 32'h0001_03FC, 32'h0, lat, r, e, c, gw);
        n_checks++;
        if (lat !== 1 || e !== 1'b0 || r !== 32'hC0FFEE01 || r !== e_rd || c !== 1'b0) begin
            n_fail++;
            $display("FAIL window_top: lat=%0d err=%0b rdata=%h cen=%0b, expected lat=1 err=0 rdata=c0ffee01 cen=0", lat, e, r, c);
        end
    endtask

    task automatic test_no_rmw();
        int lat, gw, e_lat;
        logic [31:0] r, e_rd, pre;
        logic e, c, e_err, e_acc;
        sel = 1'b1;
        pre = $urandom;
        model_txn(1'b1, 4'hF, 32'h0C, pre, e_lat, e_rd, e_err, e_acc);
        do_txn(1'b1, 4'hF, 32'h0C, pre, lat, r, e, c, gw);
        model_txn(1'b1, 4'b0011, 32'h0C, ~pre, e_lat, e_rd, e_err, e_acc);
        do_txn(1'b1, 4'b0011, 32'h0C, ~pre, lat, r, e, c, gw);
        n_checks++;
        if (lat !== 1 || e !== 1'b1 || c !== 1'b1 || r !== 32'h0 || e !== e_err) begin
            n_fail++;
            $display("FAIL normw_partial: lat=%0d err=%0b cen=%0b rdata=%h, expected lat=1 err=1 cen=1 rdata=0", lat, e, c, r);
        end
        model_txn(1'b1, 4'h0, 32'h0C, ~pre, e_lat, e_rd, e_err, e_acc);
        do_txn(1'b1, 4'h0, 32'h0C, ~pre, lat, r, e, c, gw);
        n_checks++;
        if (lat !== 1 || e !== 1'b0 || c !== 1'b1) begin
            n_fail++;
            $display("FAIL normw_be0: lat=%0d err=%0b cen=%0b, expected lat=1 err=0 cen=1", lat, e, c);
        end
        model_txn(1'b0, 4'h0, 32'h0C, 32'h0, e_lat, e_rd, e_err, e_acc);
        do_txn(1'b0, 4'h0, 32'h0C, 32'h0, lat, r, e, c, gw);
        n_checks++;
        if (lat !== 1 || e !== 1'b0 || r !== pre || r !== e_rd) begin
            n_fail++;
            $display("FAIL normw_unchanged: lat=%0d err=%0b rdata=%h, expected lat=1 err=0 rdata=%h", lat, e, r, pre);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_rd [9];
        logic [31:0] t_addr, t_wdata;
        logic        t_we;
        int          e_lat;
        logic        e_err, e_acc;
        sel = 1'b0;
        for (int i = 0; i <= 9; i++) begin
            @(negedge clk);
            if (i > 0) begin
                n_checks++;
                if (rvalid !== 1'b1 || err !== 1'b0 || rdata !== exp_rd[i-1]) begin
                    n_fail++;
                    $display("FAIL b2b_resp[%0d]: rvalid=%0b err=%0b rdata=%h, expected rvalid=1 err=0 rdata=%h",
                             i - 1, rvalid, err, rdata, exp_rd[i-1]);
                end
            end
            if (i < 9) begin
                t_we    = (i == 0);
                t_addr  = (i <= 1) ? BASE_A + 32'h50 : BASE_A + 32'(4 * (i - 2));
                t_wdata = $urandom;
                model_txn(t_we, 4'hF, t_addr, t_wdata, e_lat, exp_rd[i], e_err, e_acc);
                req = 1'b1; we = t_we; be = 4'hF; addr = t_addr; wdata = t_wdata;
                #1;
                n_checks++;
                if (gnt !== 1'b1) begin
                    n_fail++;
                    $display("FAIL b2b_gnt[%0d]: gnt=%0b, expected 1", i, gnt);
                end
            end else begin
                req = 1'b0; we = 1'b0;
            end
        end
    endtask

    task automatic test_random(input logic which, input int count);
        int          lat, gw, e_lat, idx;
        logic [31:0] r, e_rd, t_addr, t_wdata, base;
        logic [3:0]  t_be;
        logic        t_we, e, c, e_err, e_acc;
        sel  = which;
        base = which ? BASE_B : BASE_A;
        for (int i = 0; i < count; i++) begin
            t_we    = 1'($urandom_range(0, 1));
            t_be    = 4'($urandom);
            t_wdata = $urandom;
            idx     = $urandom_range(0, 15);
            case ($urandom_range(0, 7))
                0:       t_addr = base + 32'd1024 + 32'(4 * idx);
                1:       t_addr = base - 32'd4;
                default: t_addr = base + 32'(4 * idx);
            endcase
            t_addr[1:0] = 2'($urandom_range(0, 3));
            model_txn(t_we, t_be, t_addr, t_wdata, e_lat, e_rd, e_err, e_acc);
            do_txn(t_we, t_be, t_addr, t_wdata, lat, r, e, c, gw);
            n_checks++;
            if (lat !== e_lat || e !== e_err || r !== e_rd || c !== !e_acc) begin
                n_fail++;
                $display("FAIL random[%0d.%0d] we=%0b be=%h addr=%h: lat=%0d err=%0b rdata=%h cen=%0b, expected lat=%0d err=%0b rdata=%h cen=%0b",
                         which, i, t_we, t_be, t_addr, lat, e, r, c, e_lat, e_err, e_rd, !e_acc);
            end
        end
    endtask

    task automatic test_reset_in_rmw();
        int lat, gw, e_lat;
        logic [31:0] r, e_rd;
        logic e, c, e_err, e_acc, seen;
        sel = 1'b0;
        model_txn(1'b1, 4'hF, BASE_A + 32'h24, 32'h55667788, e_lat, e_rd, e_err, e_acc);
        do_txn(1'b1, 4'hF, BASE_A + 32'h24, 32'h55667788, lat, r, e, c, gw);
        @(negedge clk);
        req = 1'b1; we = 1'b1; be = 4'b0001; addr = BASE_A + 32'h24; wdata = 32'h0000_00FF;
        #1;
        n_checks++;
        if (gnt !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_rmw_grant: gnt=%0b, expected 1", gnt);
        end
        @(negedge clk);
        req = 1'b0; we = 1'b0; be = 4'h0;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (cen !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_rmw_cen: cen=%0b, expected 1", cen);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            seen |= rvalid;
        end
        n_checks++;
        if (seen !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_rmw_rvalid: rvalid seen=%0b, expected 0", seen);
        end
        model_txn(1'b0, 4'h0, BASE_A + 32'h24, 32'h0, e_lat, e_rd, e_err, e_acc);
        do_txn(1'b0, 4'h0, BASE_A + 32'h24, 32'h0, lat, r, e, c, gw);
        n_checks++;
        if (gw !== 0 || lat !== 1 || r !== 32'h55667788 || r !== e_rd) begin
            n_fail++;
            $display("FAIL rst_rmw_unchanged: gwait=%0d lat=%0d rdata=%h, expected gwait=0 lat=1 rdata=55667788", gw, lat, r);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        sel = 1'b0; req = 1'b0; we = 1'b0; be = 4'h0; addr = 32'h0; wdata = 32'h0;
        mem_clear = 1'b1;
        rst_n = 1'b0;
        for (int s = 0; s < 2; s++)
            for (int i = 0; i < WORDS; i++) ref_mem[s][i] = 32'h0;
        test_reset();
        test_full_write_read();
        test_partial_write();
        test_window();
        test_no_rmw();
        test_back_to_back();
        test_random(1'b0, 60);
        test_random(1'b1, 40);
        test_reset_in_rmw();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ibex_obi_sram_bridge.md
# ibex_obi_sram_bridge

Parametrised bridge between one Ibex OBI-style memory port (instruction or data) and a single-port word-wide SRAM macro (imem/dmem class: active-low CEN/WEN, 32-bit D/Q, one-cycle read latency). It replaces direct core-to-macro wiring with a proper req/gnt/rvalid slave. It adds an address-window decode with bus error, and byte-enable writes via read-modify-write for macros without a write mask. Two instances sit in ibex_system, one per core port.

## Interface
Parameters:
- ADDR_W, 8, SRAM word-address width; depth = 2**ADDR_W words
- BASE_ADDR, 32'h0000_0000, byte base of the window; must be aligned to 2**(ADDR_W+2)
- RMW_EN, 1, 1: partial writes by read-modify-write; 0: partial writes return error

Ports:
- clk_i  in  1  clock, all state on rising edge
- rst_ni  in  1  reset, asynchronous, active-low
- req_i  in  1  request valid
- gnt_o  out  1  grant, combinational
- we_i  in  1  1 = write
- be_i  in  4  byte enables
- addr_i  in  32  byte address; bits [1:0] ignored
- wdata_i  in  32  write data
- rvalid_o  out  1  response valid, registered
- rdata_o  out  32  read data, valid with rvalid_o
- err_o  out  1  error, valid with rvalid_o
- sram_cen_o  out  1  macro chip enable, active-low
- sram_wen_o  out  1  macro write enable, active-low
- sram_addr_o  out  ADDR_W  macro word address
- sram_d_o  out  32  macro write data
- sram_q_i  in  32  macro read data, valid the cycle after a read access

## Operation
- Word index = addr_i[ADDR_W+1:2]. In-window: addr_i[31:ADDR_W+2] == BASE_ADDR[31:ADDR_W+2].
- FSM states IDLE, RMW. gnt_o = req_i & (state==IDLE).
- Granted request classification in IDLE:
  - out-of-window: no SRAM access; response err=1, rdata=0.
  - read: cen=0, wen=1, addr=index this cycle; response rdata=sram_q_i, err=0. be_i ignored.
  - write, be_i=4'hF: cen=0, wen=0, d=wdata_i this cycle; response err=0.
  - write, be_i=4'h0: no access; response err=0.
  - write, partial, RMW_EN=1: cen=0, wen=1 read of index; latch index/wdata/be; go to RMW.
  - write, partial, RMW_EN=0: no access; response err=1.
- RMW (exactly one cycle): gnt_o=0. cen=0, wen=0, addr=latched index. d byte k = latched be[k] ? latched wdata byte k : sram_q_i byte k. Then go to IDLE.
- Idle macro outputs: cen=1, wen=1, addr=0, d=0.
- rdata_o is 0 whenever rvalid_o=0 or err_o=1. err_o is 0 whenever rvalid_o=0.

## Timing
- Reset: state=IDLE, rvalid_o=0, err_o=0, rdata_o=0, cen=1, wen=1, addr=0, d=0. gnt_o=0 while req_i=0.
- Single-cycle classes: grant in cycle N, rvalid_o in cycle N+1.
- Reads return in N+1 from sram_q_i, not registered in the bridge.
- Back-to-back reads or full writes: one grant per cycle and one rvalid per cycle.
- Partial write (RMW_EN=1): grant N, read N, write N+1, rvalid N+2. gnt_o=0 in N+1.
- A new request can be granted in N+2 alongside the RMW response.
- Read immediately after a write to the same word returns the new data; the macro write completes at the write edge.
- Partial write after a partial write to the same word: the second read occurs after the first write edge, so both merges are preserved.
- Reset asserted in RMW: the write is not issued if reset precedes its edge. FSM returns to IDLE and no rvalid_o is produced.
- Top window address (index = 2**ADDR_W-1) is legal. BASE_ADDR + 4*2**ADDR_W errors.

## Test plan
- Reset then idle: rst_ni low 3 cycles, release -> all outputs at reset values, cen=1, gnt_o=0 with req_i=0.
- Full write then read: write 0x0000_0010 data 0xDEADBEEF be=F, next cycle read same -> rvalid one cycle after each grant, second rdata_o=0xDEADBEEF, err_o=0.
- Partial write: preload word 4 = 0x11223344, write be=4'b0101 data 0xAABBCCDD -> gnt_o low one cycle, rvalid at N+2, subsequent read = 0x11BB33DD.
- Window error: BASE_ADDR=0x0001_0000, ADDR_W=8, read 0x0001_0400 -> err_o=1, rdata_o=0, cen stays 1. Read 0x0001_03FC -> err_o=0.
- RMW_EN=0: write be=4'b0011 -> err_o=1, no SRAM access, memory unchanged. be=0 write -> err_o=0, no access.
- Streaming plus reset: 8 back-to-back reads -> 8 consecutive rvalid. Then a partial write with rst_ni pulsed low during RMW -> no write (word unchanged), no rvalid, FSM IDLE.
